// File: rtl/lcd_pkg.sv
// Shared types, command constants and power-up init ROM for the LCD command driver.
package lcd_pkg;

    typedef enum logic [2:0] {
        INIT_WAIT,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_cmd_t;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    localparam int         LCD_INIT_LEN = 6;
    localparam logic [7:0] LCD_INIT_ROM [0:LCD_INIT_LEN-1] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    // Clear and return-home (02/03, bit 0 is don't-care) need the long settle time.
    function automatic logic is_slow_cmd(input lcd_cmd_t c);
        return !c.rs && ((c.data == LCD_CMD_CLEAR) || (c.data[7:1] == LCD_CMD_HOME[7:1]));
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_cmd_driver_if.sv
// LSU-to-LCD command handshake: valid/ready transfer of one {rs, byte} command.
interface lcd_cmd_driver_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic [7:0] cmd_data;

    modport master (output cmd_valid, cmd_rs, cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, cmd_rs, cmd_data, output cmd_ready);

endinterface

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; DEPTH must be a power of two.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  lcd_cmd_t wdata_i,
    input  logic     pop_i,
    output lcd_cmd_t rdata_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(DEPTH);

    lcd_cmd_t    r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_push;
    logic        w_pop;

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata_i;
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign rdata_o = r_mem[r_rptr[AW-1:0]];
    assign empty_o = (r_wptr == r_rptr);
    assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/lcd_cmd_driver.sv
// Queues LSU LCD commands and replays them as HD44780 8-bit write cycles.
// Optional LCD_INIT_SEQ_EN: power-up delay plus built-in init sequence before accepting commands.
module lcd_cmd_driver
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETUP_CYC     = 2,
    parameter int PULSE_CYC     = 25,
    parameter int HOLD_CYC      = 2,
    parameter int CMD_WAIT_CYC  = 2000,
    parameter int CLR_WAIT_CYC  = 82000,
    parameter int INIT_WAIT_CYC = 750000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    lcd_cmd_driver_if.slave  cmd_if,
    output logic             busy_o,
    output logic             lcd_on_o,
    output logic             lcd_en_o,
    output logic             lcd_rs_o,
    output logic             lcd_rw_o,
    output logic [7:0]       lcd_data_o
);

    localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, PULSE_CYC), max2(HOLD_CYC, CMD_WAIT_CYC)),
                                  max2(CLR_WAIT_CYC, INIT_WAIT_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 1);
`ifdef LCD_INIT_SEQ_EN
    localparam logic [CNT_W-1:0] INIT_LD  = CNT_W'(INIT_WAIT_CYC - 1);
`endif

    lcd_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_en;
    lcd_cmd_t         r_cmd;
    lcd_cmd_t         w_head;
    lcd_cmd_t         w_wdata;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_init_busy;

`ifdef LCD_INIT_SEQ_EN
    logic             r_init_active;
    logic [2:0]       r_init_idx;

    assign w_init_busy = r_init_active;
`else
    assign w_init_busy = 1'b0;
`endif

    assign cmd_if.cmd_ready = !w_full && !w_init_busy;
    assign w_push           = cmd_if.cmd_valid && cmd_if.cmd_ready;
    assign w_wdata          = '{rs: cmd_if.cmd_rs, data: cmd_if.cmd_data};
    assign w_pop            = (r_state == IDLE) && !w_empty && !w_init_busy;

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .wdata_i (w_wdata),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Each state loads the counter on entry and leaves when it reaches zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_en  <= 1'b0;
            r_cmd <= '0;
`ifdef LCD_INIT_SEQ_EN
            r_state       <= INIT_WAIT;
            r_cnt         <= INIT_LD;
            r_init_active <= 1'b1;
            r_init_idx    <= '0;
`else
            r_state <= IDLE;
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
`ifdef LCD_INIT_SEQ_EN
                INIT_WAIT: begin
                    if (r_cnt == '0) begin
                        r_cmd      <= '{rs: 1'b0, data: LCD_INIT_ROM[0]};
                        r_init_idx <= 3'd1;
                        r_state    <= SETUP;
                        r_cnt      <= SETUP_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                IDLE: begin
`ifdef LCD_INIT_SEQ_EN
                    if (r_init_active) begin
                        r_cmd      <= '{rs: 1'b0, data: LCD_INIT_ROM[r_init_idx]};
                        r_init_idx <= r_init_idx + 1'b1;
                        r_state    <= SETUP;
                        r_cnt      <= SETUP_LD;
                    end else
`endif
                    if (w_pop) begin
                        r_cmd   <= w_head;
                        r_state <= SETUP;
                        r_cnt   <= SETUP_LD;
                    end
                end
                SETUP: begin
                    if (r_cnt == '0) begin
                        r_en    <= 1'b1;
                        r_state <= PULSE;
                        r_cnt   <= PULSE_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                PULSE: begin
                    if (r_cnt == '0) begin
                        r_en    <= 1'b0;
                        r_state <= HOLD;
                        r_cnt   <= HOLD_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= WAIT;
                        r_cnt   <= is_slow_cmd(r_cmd) ? CLR_LD : CMD_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
`ifdef LCD_INIT_SEQ_EN
                        if (r_init_active && (r_init_idx == 3'(LCD_INIT_LEN))) r_init_active <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o     = w_init_busy || (r_state != IDLE) || !w_empty;
    assign lcd_on_o   = 1'b1;
    assign lcd_en_o   = r_en;
    assign lcd_rs_o   = r_cmd.rs;
    assign lcd_rw_o   = 1'b0;
    assign lcd_data_o = r_cmd.data;

endmodule

// File: tb/tb_lcd_cmd_driver.sv
// Scoreboard bench for lcd_cmd_driver: directed commands queue expected pin activity for a negedge monitor.
module tb_lcd_cmd_driver;
    import lcd_pkg::*;

    localparam int PULSE = 3;
`ifdef LCD_INIT_SEQ_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy, lcd_on, lcd_en, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    lcd_cmd_driver_if cmd_if();

    lcd_cmd_driver #(
        .FIFO_DEPTH    (4),
        .SETUP_CYC     (1),
        .PULSE_CYC     (PULSE),
        .HOLD_CYC      (1),
        .CMD_WAIT_CYC  (4),
        .CLR_WAIT_CYC  (10),
        .INIT_WAIT_CYC (5)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cmd_if     (cmd_if),
        .busy_o     (busy),
        .lcd_on_o   (lcd_on),
        .lcd_en_o   (lcd_en),
        .lcd_rs_o   (lcd_rs),
        .lcd_rw_o   (lcd_rw),
        .lcd_data_o (lcd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] cmd;
        int         wait_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    // Monitor: compares every EN pulse against the scoreboard and measures pulse/settle timing.
    logic       m_prev_en = 1'b0;
    logic [8:0] m_prev_pins = '0;
    logic [8:0] m_cur = '0;
    logic [8:0] m_pins;
    exp_t       m_e;
    int         m_hi = 0, m_lo = 0, m_pend = -1, m_cur_wait = 0;

    always @(negedge clk) begin
        m_pins = {lcd_rs, lcd_data};
        if (rst) begin
            m_prev_en = 1'b0;
            m_pend    = -1;
            m_hi      = 0;
            m_lo      = 0;
        end else begin
            if (lcd_en && !m_prev_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", int'(m_pins), -1);
                    m_cur_wait = -1;
                end else begin
                    m_e = exp_q.pop_front();
                    check("cmd_pins", int'(m_pins), int'(m_e.cmd));
                    m_cur_wait = m_e.wait_cyc;
                end
                check("setup_stable", int'(m_pins), int'(m_prev_pins));
                if (m_pend >= 0) begin
                    check("wait_len_b2b", m_lo - 3, m_pend);
                    m_pend = -1;
                end
                m_cur = m_pins;
                m_hi  = 1;
            end else if (lcd_en) begin
                m_hi++;
                check("pulse_stable", int'(m_pins), int'(m_cur));
            end else if (m_prev_en) begin
                check("pulse_len", m_hi, PULSE);
                check("hold_stable", int'(m_pins), int'(m_cur));
                m_lo   = 1;
                m_pend = m_cur_wait;
            end else begin
                m_lo++;
                if (m_pend >= 0 && !busy) begin
                    check("wait_len_idle", m_lo - 2, m_pend);
                    m_pend = -1;
                end
            end
            m_prev_en = lcd_en;
        end
        m_prev_pins = m_pins;
    end

    task automatic push(input logic rs, input logic [7:0] d, input int w, input bit expect_out);
        int guard;
        if (expect_out) exp_q.push_back('{cmd: {rs, d}, wait_cyc: w});
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_rs    = rs;
        cmd_if.cmd_data  = d;
        guard = 0;
        while (!cmd_if.cmd_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("push_accept_in_time", int'(guard < 200), 1);
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check("idle_in_time", int'(guard < 300), 1);
    endtask

    // With the init sequence built in, every reset replays it before commands are accepted.
    task automatic after_reset();
`ifdef LCD_INIT_SEQ_EN
        int guard;
        exp_q.push_back('{cmd: 9'h038, wait_cyc: 4});
        exp_q.push_back('{cmd: 9'h038, wait_cyc: 4});
        exp_q.push_back('{cmd: 9'h038, wait_cyc: 4});
        exp_q.push_back('{cmd: 9'h00C, wait_cyc: 4});
        exp_q.push_back('{cmd: 9'h001, wait_cyc: 10});
        exp_q.push_back('{cmd: 9'h006, wait_cyc: 4});
        guard = 0;
        while (!cmd_if.cmd_ready && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check("init_ready_in_time", int'(guard < 300), 1);
        check("init_all_emitted", exp_q.size(), 0);
        check("init_busy_done", int'(busy), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_rs    = 1'b0;
        cmd_if.cmd_data  = 8'h00;
        rst              = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", int'(lcd_en), 0);
        check("rst_rs", int'(lcd_rs), 0);
        check("rst_data", int'(lcd_data), 0);
        check("rst_rw", int'(lcd_rw), 0);
        check("rst_on", int'(lcd_on), 1);
        check("rst_busy", int'(busy), INIT_EN ? 1 : 0);
        check("rst_ready", int'(cmd_if.cmd_ready), INIT_EN ? 0 : 1);
        rst = 1'b0;
        after_reset();

        // Single data write and busy duration
        push(1'b1, 8'h41, 4, 1'b1);
        c = 0;
        while (busy && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        check("busy_after_push", c, 10);
        check("rw_low", int'(lcd_rw), 0);

        // Clear/home versus normal settle times, including the RS and bit-0 boundaries
        push(1'b0, 8'h01, 10, 1'b1); wait_idle();
        push(1'b0, 8'h80, 4, 1'b1);  wait_idle();
        push(1'b1, 8'h01, 4, 1'b1);  wait_idle();
        push(1'b0, 8'h03, 10, 1'b1); wait_idle();
        push(1'b0, 8'h02, 10, 1'b1); wait_idle();
        push(1'b0, 8'h04, 4, 1'b1);  wait_idle();

        // Back-to-back burst: fill the queue while the first command is on the pins
        push(1'b1, 8'h48, 4, 1'b1);
        push(1'b1, 8'h45, 4, 1'b1);
        push(1'b1, 8'h4C, 4, 1'b1);
        push(1'b1, 8'h4C, 4, 1'b1);
        push(1'b1, 8'h4F, 4, 1'b1);
        check("full_ready_low", int'(cmd_if.cmd_ready), 0);
        c = 0;
        while (!cmd_if.cmd_ready && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        check("ready_after_first_pop", c, 7);
        push(1'b1, 8'h21, 4, 1'b1);
        wait_idle();

        // Reset during PULSE aborts the transfer and flushes the queue
        push(1'b1, 8'h55, 4, 1'b1);
        push(1'b1, 8'hAA, 4, 1'b0);
        c = 0;
        while (!lcd_en && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check("pulse_seen", int'(lcd_en), 1);
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_en", int'(lcd_en), 0);
        check("abort_busy", int'(busy), INIT_EN ? 1 : 0);
        check("abort_ready", int'(cmd_if.cmd_ready), INIT_EN ? 0 : 1);
        @(posedge clk); #1;
        rst = 1'b0;
        after_reset();
        repeat (6) @(posedge clk);
        #1;
        check("flushed_busy", int'(busy), 0);
        check("flushed_en", int'(lcd_en), 0);
        push(1'b0, 8'hC0, 4, 1'b1);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        check("wait_resolved", m_pend, -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
